// File: rtl/word_seq_pkg.sv
// rtl/word_seq_pkg.sv - shared types and sizing helpers for the word chip sequencer
package word_seq_pkg;

    localparam int N_CHIPS_DEFAULT = 6;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } seq_state_e;

    // Count must represent 0..n_chips inclusive.
    function automatic int cnt_width(input int n_chips);
        return $clog2(n_chips + 1);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - parametrised binary index to one-hot decoder
module onehot_dec #(
    parameter int N_CHIPS = 6,
    parameter int IDX_W   = 3
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [N_CHIPS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_CHIPS; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/word_chip_sequencer.sv
// rtl/word_chip_sequencer.sv - word length accumulator issuing a held one-hot chip select
module word_chip_sequencer
    import word_seq_pkg::*;
#(
    parameter int N_CHIPS = N_CHIPS_DEFAULT,
    parameter int CNT_W   = cnt_width(N_CHIPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               char_in,
    input  logic               back_in,
    input  logic               commit,
    input  logic               clear,
    input  logic               ack,
    output logic [N_CHIPS-1:0] sel,
    output logic               sel_valid,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(N_CHIPS);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [N_CHIPS-1:0] sel_q, sel_d;
    logic [N_CHIPS-1:0] dec_onehot;

    // Word length L selects chip L-1.
    onehot_dec #(
        .N_CHIPS (N_CHIPS),
        .IDX_W   (CNT_W)
    ) u_dec (
        .idx    (count_q - CNT_W'(1)),
        .en     (1'b1),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sel_d      = sel_q;
        if (clear) begin
            state_d    = COLLECT;
            count_d    = '0;
            overflow_d = 1'b0;
            sel_d      = '0;
        end else if (en) begin
            case (state_q)
                COLLECT: begin
                    if (commit && (count_q != '0)) begin
                        sel_d   = dec_onehot;
                        state_d = HOLD;
                    end else if (char_in && !back_in) begin
                        if (count_q < COUNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (back_in && !char_in) begin
                        if (count_q != '0) begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state_d    = COLLECT;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        sel_d      = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sel_q      <= sel_d;
        end
    end

    // en gates the select with no latency; sel_q itself is retained.
    assign sel       = sel_q & {N_CHIPS{en}};
    assign sel_valid = (state_q == HOLD) && en;
    assign count     = count_q;
    assign full      = (count_q == COUNT_MAX);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_word_chip_sequencer.sv
// tb/tb_word_chip_sequencer.sv - scoreboard bench for word_chip_sequencer (6 and 10 chips)
module tb_word_chip_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst6 = 1'b1, en6 = 1'b1, ch6 = 1'b0, bk6 = 1'b0, cm6 = 1'b0, cl6 = 1'b0, ak6 = 1'b0;
    logic [5:0] sel6;
    logic       sv6, full6, ovf6;
    logic [2:0] cnt6;

    logic       rst10 = 1'b1, en10 = 1'b1, ch10 = 1'b0, bk10 = 1'b0, cm10 = 1'b0, cl10 = 1'b0, ak10 = 1'b0;
    logic [9:0] sel10;
    logic       sv10, full10, ovf10;
    logic [3:0] cnt10;

    word_chip_sequencer #(.N_CHIPS(6)) dut6 (
        .clk(clk), .reset(rst6), .en(en6), .char_in(ch6), .back_in(bk6),
        .commit(cm6), .clear(cl6), .ack(ak6),
        .sel(sel6), .sel_valid(sv6), .count(cnt6), .full(full6), .overflow(ovf6)
    );

    word_chip_sequencer #(.N_CHIPS(10)) dut10 (
        .clk(clk), .reset(rst10), .en(en10), .char_in(ch10), .back_in(bk10),
        .commit(cm10), .clear(cl10), .ack(ak10),
        .sel(sel10), .sel_valid(sv10), .count(cnt10), .full(full10), .overflow(ovf10)
    );

    typedef struct {
        bit         which;
        logic [9:0] sel;
        logic       sv;
        logic [3:0] cnt;
        logic       full;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step(input bit which, input logic e, input logic c, input logic b,
                        input logic cm, input logic cl, input logic a, input logic r,
                        input logic [9:0] xs, input logic xv, input logic [3:0] xc,
                        input logic xf, input logic xo, input string nm);
        exp_t x;
        @(negedge clk);
        ch6 = 1'b0; bk6 = 1'b0; cm6 = 1'b0; cl6 = 1'b0; ak6 = 1'b0;
        ch10 = 1'b0; bk10 = 1'b0; cm10 = 1'b0; cl10 = 1'b0; ak10 = 1'b0;
        if (!which) begin
            en6 = e; ch6 = c; bk6 = b; cm6 = cm; cl6 = cl; ak6 = a; rst6 = r;
        end else begin
            en10 = e; ch10 = c; bk10 = b; cm10 = cm; cl10 = cl; ak10 = a; rst10 = r;
        end
        x.which = which; x.sel = xs; x.sv = xv; x.cnt = xc; x.full = xf; x.ovf = xo; x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs observed just after each edge, inputs of that cycle still applied.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [9:0] a_sel;
            logic       a_sv, a_full, a_ovf;
            logic [3:0] a_cnt;
            x = exp_q.pop_front();
            if (!x.which) begin
                a_sel = {4'b0, sel6}; a_sv = sv6; a_cnt = {1'b0, cnt6}; a_full = full6; a_ovf = ovf6;
            end else begin
                a_sel = sel10; a_sv = sv10; a_cnt = cnt10; a_full = full10; a_ovf = ovf10;
            end
            n_checks++;
            if (a_sel === x.sel && a_sv === x.sv && a_cnt === x.cnt &&
                a_full === x.full && a_ovf === x.ovf) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got sel=%b sv=%b cnt=%0d full=%b ovf=%b, want sel=%b sv=%b cnt=%0d full=%b ovf=%b",
                         x.name, a_sel, a_sv, a_cnt, a_full, a_ovf,
                         x.sel, x.sv, x.cnt, x.full, x.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 6-chip instance: args e,ch,bk,cm,cl,ak,rst then expected sel,sv,cnt,full,ovf
        step(0, 1,0,0,0,0,0,1, 10'b0,      0, 4'd0, 0, 0, "reset");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "char1");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "char2");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd3, 0, 0, "char3");
        step(0, 1,0,0,1,0,0,0, 10'b000100, 1, 4'd3, 0, 0, "commit3");
        step(0, 1,0,0,0,0,0,0, 10'b000100, 1, 4'd3, 0, 0, "hold3");
        step(0, 1,0,0,0,0,1,0, 10'b0,      0, 4'd0, 0, 0, "ack3");
        for (int i = 1; i <= 6; i++)
            step(0, 1,1,0,0,0,0,0, 10'b0,  0, 4'(i), (i == 6), 0, "sat_char");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd6, 1, 1, "overflow");
        step(0, 1,0,0,1,0,0,0, 10'b100000, 1, 4'd6, 1, 1, "commit6");
        step(0, 1,0,0,0,0,1,0, 10'b0,      0, 4'd0, 0, 0, "ack6_ovf_clr");
        step(0, 1,0,1,0,0,0,0, 10'b0,      0, 4'd0, 0, 0, "back_at0");
        step(0, 1,0,0,1,0,0,0, 10'b0,      0, 4'd0, 0, 0, "commit_at0");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "char_a");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "char_b");
        step(0, 1,1,1,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "char_back");
        step(0, 1,0,1,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "back1");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "char_c");
        step(0, 1,0,0,1,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "commit2");
        step(0, 1,1,0,0,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "hold_char");
        step(0, 1,0,1,0,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "hold_back");
        step(0, 1,0,0,1,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "hold_commit");
        step(0, 1,0,0,0,1,0,0, 10'b0,      0, 4'd0, 0, 0, "clear_hold");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "char_d");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "char_e");
        step(0, 1,0,0,1,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "commit2b");
        step(0, 0,0,0,0,0,0,0, 10'b0,      0, 4'd2, 0, 0, "en0_hold");
        step(0, 0,0,0,0,0,1,0, 10'b0,      0, 4'd2, 0, 0, "en0_ack");
        step(0, 1,0,0,0,0,0,0, 10'b000010, 1, 4'd2, 0, 0, "en1_restore");
        step(0, 1,0,0,0,0,1,0, 10'b0,      0, 4'd0, 0, 0, "ack2");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "char_after_ack");
        step(0, 1,0,0,0,0,1,0, 10'b0,      0, 4'd1, 0, 0, "ack_collect");
        step(0, 0,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "en0_char");
        step(0, 1,1,0,1,0,0,0, 10'b000001, 1, 4'd1, 0, 0, "commit_char");
        step(0, 1,0,0,0,0,0,1, 10'b0,      0, 4'd0, 0, 0, "reset_hold");
        step(0, 1,1,0,0,0,0,0, 10'b0,      0, 4'd1, 0, 0, "char_post_reset");

        // 10-chip instance
        step(1, 1,0,0,0,0,0,1, 10'b0,      0, 4'd0, 0, 0, "r10_reset");
        for (int i = 1; i <= 9; i++)
            step(1, 1,1,0,0,0,0,0, 10'b0,  0, 4'(i), 0, 0, "r10_char");
        step(1, 1,0,0,1,0,0,0, 10'h100,    1, 4'd9, 0, 0, "r10_commit9");
        step(1, 1,0,0,0,0,1,0, 10'b0,      0, 4'd0, 0, 0, "r10_ack9");
        for (int i = 1; i <= 10; i++)
            step(1, 1,1,0,0,0,0,0, 10'b0,  0, 4'(i), (i == 10), 0, "r10_sat");
        step(1, 1,1,0,0,0,0,0, 10'b0,      0, 4'd10, 1, 1, "r10_overflow");
        step(1, 1,0,0,1,0,0,0, 10'h200,    1, 4'd10, 1, 1, "r10_commit10");
        step(1, 1,0,0,0,0,1,0, 10'b0,      0, 4'd0, 0, 0, "r10_ack10");

        @(negedge clk);
        ch10 = 1'b0; cm10 = 1'b0; ak10 = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_chip_sequencer.md
# word_chip_sequencer

- Parametrised, registered successor to the fixed 3-to-6 word-length chip decoder.
- Accumulates a word length from per-character and backspace events.
- On commit, latches the length and drives a one-hot chip select that holds until the selected chip acknowledges.
- Sits between the keyboard/input front end and the per-length word-storage chips.

## Interface
Parameters:
- N_CHIPS, 6: number of selectable chips; word length L (1..N_CHIPS) selects chip L-1.
- CNT_W, $clog2(N_CHIPS+1): count width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global enable; gates input events and the sel output.
- char_in  in  1  one-cycle pulse: one character typed.
- back_in  in  1  one-cycle pulse: one character deleted.
- commit  in  1  one-cycle pulse: word complete, issue chip select.
- clear  in  1  abort; return to empty COLLECT.
- ack  in  1  selected chip has consumed the word.
- sel  out  N_CHIPS  one-hot chip select, all zero when idle.
- sel_valid  out  1  high while in HOLD and en=1.
- count  out  CNT_W  current accumulated length.
- full  out  1  count == N_CHIPS.
- overflow  out  1  sticky: char_in arrived while full.

## Operation
- States: COLLECT (reset state) and HOLD.
- Event priority: reset > clear > state actions.
- Event gating: char_in, back_in, commit and ack have effect only when en=1. State is frozen while en=0.
- COLLECT:
  - char_in alone: count+1 if count<N_CHIPS; otherwise count holds and overflow is set.
  - back_in alone: count-1 if count>0; otherwise no change.
  - char_in and back_in together: count unchanged, overflow unchanged.
  - commit with count>=1: latch sel_q = onehot(count-1); go to HOLD. Any char_in/back_in in the same cycle is ignored.
  - commit with count==0: ignored; stay in COLLECT.
  - ack in COLLECT: ignored.
- HOLD:
  - sel_q and count are stable; char_in, back_in and commit are ignored.
  - ack: clear sel_q, count and overflow; return to COLLECT.
- clear (any state): clears sel_q, count and overflow; goes to COLLECT.
- Outputs:
  - sel = sel_q & {N_CHIPS{en}}, combinational gate so en takes effect with zero latency.
  - sel_valid = (state==HOLD) & en.
  - full is a combinational decode of count.
- Arithmetic: count never wraps in either direction. The invariant 0 <= count <= N_CHIPS always holds.

## Timing
- Reset values: sel=0, sel_valid=0, count=0, full=0, overflow=0, state=COLLECT.
- Latencies:
  - char_in/back_in sampled at edge k: count updated and visible after edge k (1-cycle latency).
  - commit at edge k: sel and sel_valid high from edge k until the edge that samples ack.
  - ack sampled at edge m: sel=0 and count=0 after edge m. A new char_in is accepted from edge m+1.
- Minimum HOLD duration: one cycle (ack may be high on the first HOLD cycle).
- Reset or clear mid-HOLD: sel drops after that edge; no ack is required.
- en dropped mid-HOLD: sel goes to 0 immediately while sel_q is retained; sel reappears when en returns.

## Structure
- Shared package word_seq_pkg:
  - state enum {COLLECT, HOLD};
  - the CNT_W computation as a function;
  - N_CHIPS default constant.
- Sub-module onehot_dec: parametrised combinational binary-to-one-hot decoder (inputs idx and en, output N_CHIPS bits), used to form sel_q from count-1.
- Top level holds the FSM, the saturating up/down counter and the overflow flag.

## Test plan
- Reset, then 3x char_in, then commit -> count=3; sel=6'b000100 one cycle after commit; sel_valid=1; ack -> sel=0, count=0 next cycle.
- 7x char_in with N_CHIPS=6 -> count saturates at 6, full=1, overflow=1; commit -> sel=6'b100000; ack -> overflow=0.
- back_in at count=0 -> count stays 0; commit at count=0 -> no HOLD, sel=0; char_in and back_in together at count=2 -> count stays 2.
- In HOLD with sel=6'b000010: char_in, back_in and commit pulses -> sel and count unchanged; clear -> sel=0, count=0, COLLECT after one edge without ack.
- en=0 during HOLD -> sel=0 and sel_valid=0 in the same cycle, ack ignored; en=1 -> sel=6'b000010 restored; then ack clears.
- Synchronous reset asserted mid-HOLD for one cycle -> all outputs 0 after that edge; N_CHIPS=10 rerun with length 9 -> sel bit 8 set, CNT_W=4.
